renas_ahb_dpram: RTL
====================

// Module: renas_ahb_dpram
// PURPOSE
//  Dual-port AHB-lite slave wrapping one word-organised SRAM array. It is the main memory for the renas
//  MCU, with port A on the I-AHB and port B on the D-AHB. Both ports support read and write, and each
//  port has its own data-phase FSM. The block has programmable wait states, byte/halfword/word writes,
//  base-address decoding and ERROR responses. Port A has priority on same-word write collisions.
// PARAMETERS
//  DATA_W       32          data bus / SRAM word width; must be 32 (hsize decode is 32-bit-lane based)
//  ADDR_W       32          haddr width
//  DEPTH        4096        SRAM words; power of two
//  BASE_ADDR    32'h400     byte address mapped to word 0
//  WAIT_STATES  0           extra hreadyout=0 cycles per transfer, 0..15, identical on both ports
//  A_WRITABLE   1           0 -> port A writes return ERROR (read-only instruction port)
// PORTS
//  clk_l2         in   1       single clock, all logic on posedge
//  rst            in   1       asynchronous, active-high reset
//  x_hsel         in   1       slave select (x = a, b for every port below)
//  x_htrans       in   2       AHB transfer type; only NONSEQ/SEQ (htrans[1]=1) start a transfer
//  x_hwrite       in   1       1 = write
//  x_hsize        in   3       0 byte, 1 halfword, 2 word; >2 -> ERROR
//  x_haddr        in   ADDR_W  byte address
//  x_hwdata       in   DATA_W  write data, sampled in data phase
//  x_hready       in   1       bus-level HREADY (address phase accepted only when 1)
//  x_hreadyout    out  1       slave ready
//  x_hresp        out  1       0 OKAY, 1 ERROR
//  x_hrdata       out  DATA_W  read data, valid when hreadyout=1 on a read's final data cycle
// BEHAVIOUR
//  Reset (async, any time incl. mid-transfer): hreadyout=1, hresp=0, hrdata=0, FSM IDLE, wait counters 0.
//   Pending writes are dropped. The SRAM array is NOT cleared.
//  Accept: at posedge where hsel & htrans[1] & hready, latch hwrite/hsize/haddr. Word index is
//   (haddr-BASE_ADDR)>>2.
//  Error checks run at accept:
//   - offset = haddr-BASE_ADDR (unsigned, wraps) >= DEPTH*4 -> ERROR
//   - misaligned: hsize=1 with haddr[0]!=0, or hsize=2 with haddr[1:0]!=0 -> ERROR
//   - hsize>2 -> ERROR
//   - port A write with A_WRITABLE=0 -> ERROR
//  FSM per port: IDLE -> WAIT (if WAIT_STATES>0) -> DATA -> IDLE/next; IDLE -> ERR1 -> ERR2 on error.
//   IDLE: hreadyout=1, hresp=0. Non-selected or IDLE/BUSY htrans -> zero-wait OKAY, no access.
//   WAIT: hreadyout=0 for exactly WAIT_STATES cycles (counter loaded at accept, decrements to 0).
//   DATA: hreadyout=1 for one cycle.
//     Read: hrdata = word at the latched index; the SRAM read is issued so data is registered on
//      entering DATA.
//     Write: hwdata is sampled at the end of DATA and merged per byte lanes (haddr[1:0], hsize).
//      Unwritten lanes are preserved.
//     A new accept in the DATA cycle (pipelined) moves directly to WAIT/DATA/ERR1 of the next transfer.
//   ERR1: hreadyout=0, hresp=1. ERR2: hreadyout=1, hresp=1. Then IDLE (or next accept in ERR2).
//     An errored transfer never modifies the array.
//  Latency: data phase = 1+WAIT_STATES cycles. Back-to-back transfers sustain 1 per (1+WAIT_STATES).
//  Collisions (same posedge, same word):
//   - A and B both write: lanes written by A take A data, lanes written only by B take B data.
//   - One port writes while the other reads: the reader gets OLD data (read-first).
//   - Same-port read after write to the same word: the new data is returned.
//  hrdata holds its last read value outside read DATA cycles. Writes do not update hrdata.
// TESTING
//  1. Reset mid-read: assert rst while a_hreadyout=0 (WAIT_STATES=2) -> hreadyout=1, hresp=0, hrdata=0
//     immediately; next read works normally.
//  2. B writes word 0xDEADBEEF @0x800, then A reads 0x800 -> a_hrdata=0xDEADBEEF.
//     Data phase is 1 cycle at WAIT_STATES=0 and 4 cycles at WAIT_STATES=3.
//  3. B writes word 0x11223344 @0x900, then byte 0xAA @0x902 (hsize=0), then halfword 0xBBBB @0x900,
//     then reads -> 0x11AABBBB.
//  4. Same-cycle collision @0xA00 from 0x00000000: A word write 0x12345678 and B byte write 0xFF
//     @0xA03 -> read 0x12345678. A word write concurrent with a B read of the same word -> B gets old
//     value.
//  5. Errors -> each gives 2-cycle ERROR (hreadyout 0 then 1, hresp=1) and memory is unchanged:
//     B read @0x3FC (below base), @BASE+DEPTH*4, word @0x802, hsize=3.
//     A write with A_WRITABLE=0 -> same 2-cycle ERROR, memory unchanged.
//  6. Pipelined burst: 8 back-to-back SEQ reads on A with WAIT_STATES=0 while B streams writes to
//     other words -> 8 consecutive hreadyout=1 cycles with correct data, no stalls.

Source files
------------

// File: rtl/renas_ahb_dpram_if.sv
// AHB-lite port bundle for one side of renas_ahb_dpram.
// The bus-level hready is driven by the master/interconnect side.
interface renas_ahb_dpram_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              hsel;
  logic [1:0]        htrans;
  logic              hwrite;
  logic [2:0]        hsize;
  logic [ADDR_W-1:0] haddr;
  logic [DATA_W-1:0] hwdata;
  logic              hready;
  logic              hreadyout;
  logic              hresp;
  logic [DATA_W-1:0] hrdata;

  modport master (output hsel, htrans, hwrite, hsize, haddr, hwdata, hready,
                  input  hreadyout, hresp, hrdata);
  modport slave  (input  hsel, htrans, hwrite, hsize, haddr, hwdata, hready,
                  output hreadyout, hresp, hrdata);
endinterface

// File: rtl/renas_ahb_dpram.sv
// Dual-port AHB-lite SRAM slave: per-port data-phase FSM with wait states and ERROR
// responses, shared byte-lane-writable array, port A wins same-word write collisions.
module renas_ahb_dpram_port #(
  parameter int                ADDR_W      = 32,
  parameter int                DEPTH       = 4096,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 'h400,
  parameter int                WAIT_STATES = 0,
  parameter bit                WRITABLE    = 1'b1,
  localparam int               IDX_W       = $clog2(DEPTH)
) (
  input  logic              clk_l2,
  input  logic              rst,
  input  logic              hsel,
  input  logic [1:0]        htrans,
  input  logic              hwrite,
  input  logic [2:0]        hsize,
  input  logic [ADDR_W-1:0] haddr,
  input  logic              hready,
  output logic              hreadyout,
  output logic              hresp,
  output logic              rd_go,
  output logic [IDX_W-1:0]  rd_idx,
  output logic              wr_go,
  output logic [IDX_W-1:0]  wr_idx,
  output logic [3:0]        wr_be
);
  typedef enum logic [2:0] {IDLE, WAIT, DATA, ERR1, ERR2} st_t;
  localparam logic [ADDR_W-1:0] SPAN = ADDR_W'(DEPTH) << 2;

  st_t              st, st_nx;
  logic [3:0]       cnt;
  logic             wr_l;
  logic [IDX_W-1:0] idx_l;
  logic [3:0]       be_l, be_a;
  logic [ADDR_W-1:0] off;
  logic             acc, err;
  logic             unused_bits;

  assign unused_bits = htrans[0];
  assign off = haddr - BASE_ADDR;
  assign err = (off >= SPAN) || (hsize > 3'd2) || (hwrite && !WRITABLE) ||
               (hsize == 3'd1 && haddr[0]) || (hsize == 3'd2 && haddr[1:0] != 2'b00);
  assign acc = (st == IDLE || st == DATA || st == ERR2) && hsel && htrans[1] && hready;

  always_comb begin
    case (hsize)
      3'd0:    be_a = 4'b0001 << haddr[1:0];
      3'd1:    be_a = haddr[1] ? 4'b1100 : 4'b0011;
      default: be_a = 4'b1111;
    endcase
  end

  always_comb begin
    st_nx     = st;
    hreadyout = 1'b1;
    hresp     = 1'b0;
    case (st)
      WAIT: begin
        hreadyout = 1'b0;
        if (cnt == 4'd1) st_nx = DATA;
      end
      ERR1: begin
        hreadyout = 1'b0;
        hresp     = 1'b1;
        st_nx     = ERR2;
      end
      ERR2: begin
        hresp = 1'b1;
        st_nx = IDLE;
      end
      default: st_nx = IDLE;
    endcase
    if (acc) st_nx = err ? ERR1 : ((WAIT_STATES > 0) ? WAIT : DATA);
  end

  always_ff @(posedge clk_l2 or posedge rst) begin
    if (rst) begin
      st    <= IDLE;
      cnt   <= '0;
      wr_l  <= 1'b0;
      idx_l <= '0;
      be_l  <= '0;
    end else begin
      st <= st_nx;
      if (acc) begin
        wr_l  <= hwrite;
        idx_l <= off[IDX_W+1:2];
        be_l  <= be_a;
        cnt   <= 4'(WAIT_STATES);
      end else if (st == WAIT) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  // The array read is issued on the edge that enters DATA so hrdata is registered there.
  assign rd_go  = (WAIT_STATES == 0) ? (acc && !err && !hwrite)
                                     : (st == WAIT && cnt == 4'd1 && !wr_l);
  assign rd_idx = (WAIT_STATES == 0) ? off[IDX_W+1:2] : idx_l;
  assign wr_go  = (st == DATA) && wr_l;
  assign wr_idx = idx_l;
  assign wr_be  = be_l;
endmodule

module renas_ahb_dpram #(
  parameter int                DATA_W      = 32,
  parameter int                ADDR_W      = 32,
  parameter int                DEPTH       = 4096,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 'h400,
  parameter int                WAIT_STATES = 0,
  parameter bit                A_WRITABLE  = 1'b1
) (
  input  logic clk_l2,
  input  logic rst,
  renas_ahb_dpram_if.slave a,
  renas_ahb_dpram_if.slave b
);
  localparam int IDX_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic              a_rd_go, a_wr_go, b_rd_go, b_wr_go;
  logic [IDX_W-1:0]  a_rd_idx, a_wr_idx, b_rd_idx, b_wr_idx;
  logic [3:0]        a_wr_be, b_wr_be;
  logic              a_rdy, a_rsp, b_rdy, b_rsp;
  logic [DATA_W-1:0] a_rd_word, b_rd_word, a_hrdata_q, b_hrdata_q;

  renas_ahb_dpram_port #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .BASE_ADDR(BASE_ADDR),
    .WAIT_STATES(WAIT_STATES), .WRITABLE(A_WRITABLE)) u_pa (
    .clk_l2, .rst, .hsel(a.hsel), .htrans(a.htrans), .hwrite(a.hwrite), .hsize(a.hsize),
    .haddr(a.haddr), .hready(a.hready), .hreadyout(a_rdy), .hresp(a_rsp),
    .rd_go(a_rd_go), .rd_idx(a_rd_idx), .wr_go(a_wr_go), .wr_idx(a_wr_idx), .wr_be(a_wr_be));

  renas_ahb_dpram_port #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .BASE_ADDR(BASE_ADDR),
    .WAIT_STATES(WAIT_STATES), .WRITABLE(1'b1)) u_pb (
    .clk_l2, .rst, .hsel(b.hsel), .htrans(b.htrans), .hwrite(b.hwrite), .hsize(b.hsize),
    .haddr(b.haddr), .hready(b.hready), .hreadyout(b_rdy), .hresp(b_rsp),
    .rd_go(b_rd_go), .rd_idx(b_rd_idx), .wr_go(b_wr_go), .wr_idx(b_wr_idx), .wr_be(b_wr_be));

  // A's lane writes come last so they override B's on a same-word collision.
  always_ff @(posedge clk_l2) begin
    for (int l = 0; l < 4; l++) begin
      if (b_wr_go && b_wr_be[l]) mem[b_wr_idx][8*l +: 8] <= b.hwdata[8*l +: 8];
      if (a_wr_go && a_wr_be[l]) mem[a_wr_idx][8*l +: 8] <= a.hwdata[8*l +: 8];
    end
  end

  // Same-port write committing on the read edge is forwarded; the other port's is not (read-first).
  always_comb begin
    a_rd_word = mem[a_rd_idx];
    b_rd_word = mem[b_rd_idx];
    for (int l = 0; l < 4; l++) begin
      if (a_wr_go && a_wr_idx == a_rd_idx && a_wr_be[l]) a_rd_word[8*l +: 8] = a.hwdata[8*l +: 8];
      if (b_wr_go && b_wr_idx == b_rd_idx && b_wr_be[l]) b_rd_word[8*l +: 8] = b.hwdata[8*l +: 8];
    end
  end

  always_ff @(posedge clk_l2 or posedge rst) begin
    if (rst) begin
      a_hrdata_q <= '0;
      b_hrdata_q <= '0;
    end else begin
      if (a_rd_go) a_hrdata_q <= a_rd_word;
      if (b_rd_go) b_hrdata_q <= b_rd_word;
    end
  end

  assign a.hreadyout = a_rdy;
  assign a.hresp     = a_rsp;
  assign a.hrdata    = a_hrdata_q;
  assign b.hreadyout = b_rdy;
  assign b.hresp     = b_rsp;
  assign b.hrdata    = b_hrdata_q;
endmodule
